// File: rtl/pipe_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pipe_ctrl: stall/flush sequencing for the five-stage core, including the   |
// | multi-cycle EX sequencer and a saturating stall-cycle counter.             |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module pipe_ctrl #(
  parameter int CNT_W   = 6,
  parameter int STALL_W = 6,
  parameter int PERF_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id_i,
  input  logic               stallreq_ex_i,
  input  logic               mc_start_i,
  input  logic [CNT_W-1:0]   mc_len_i,
  input  logic               flush_i,
  output logic [STALL_W-1:0] stall_o,
  output logic               flush_o,
  output logic [CNT_W-1:0]   mc_cnt_o,
  output logic               mc_done_o,
  output logic               mc_abort_o,
  output logic               busy_o,
  output logic [PERF_W-1:0]  stall_cycles_o
);

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_busy = 1'b1;

  localparam logic [STALL_W-1:0] c_stall_ex = STALL_W'(4'b1111);
  localparam logic [STALL_W-1:0] c_stall_id = STALL_W'(3'b111);

  logic [0:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_len;
  logic [PERF_W-1:0]  r_stall_cycles;

  logic [0:0]         w_next_state;
  logic [CNT_W-1:0]   w_next_cnt;
  logic [CNT_W-1:0]   w_next_len;
  logic [CNT_W-1:0]   w_len_eff;
  logic               w_seq_stall;
  logic               w_done;
  logic               w_abort;
  logic [STALL_W-1:0] w_stall;

  always_comb begin
    w_len_eff    = (mc_len_i == '0) ? CNT_W'(1) : mc_len_i;
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_len   = r_len;
    w_seq_stall  = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    if (r_state == c_idle) begin
      // A flush in the same cycle kills the op before it ever starts.
      if (mc_start_i && !flush_i) begin
        if (w_len_eff == CNT_W'(1)) begin
          w_done = 1'b1;
        end else begin
          w_seq_stall  = 1'b1;
          w_next_len   = w_len_eff;
          w_next_cnt   = CNT_W'(1);
          w_next_state = c_busy;
        end
      end
    end else begin
      if (flush_i) begin
        w_abort      = 1'b1;
        w_next_cnt   = '0;
        w_next_state = c_idle;
      end else if (r_cnt < (r_len - CNT_W'(1))) begin
        w_seq_stall = 1'b1;
        w_next_cnt  = r_cnt + CNT_W'(1);
      end else begin
        w_done       = 1'b1;
        w_next_cnt   = '0;
        w_next_state = c_idle;
      end
    end

    if (flush_i) begin
      w_stall = '0;
    end else if (w_seq_stall || stallreq_ex_i) begin
      w_stall = c_stall_ex;
    end else if (stallreq_id_i) begin
      w_stall = c_stall_id;
    end else begin
      w_stall = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= c_idle;
      r_cnt          <= '0;
      r_len          <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_len   <= w_next_len;
      if (w_stall[0] && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + PERF_W'(1);
      end
    end
  end

  // Every output, combinational ones included, is forced low during reset.
  assign stall_o        = rst ? '0 : w_stall;
  assign flush_o        = !rst && flush_i;
  assign mc_cnt_o       = (!rst && r_state == c_busy) ? r_cnt : '0;
  assign mc_done_o      = !rst && !flush_i && w_done;
  assign mc_abort_o     = !rst && w_abort;
  assign busy_o         = !rst && (r_state == c_busy);
  assign stall_cycles_o = rst ? '0 : r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_pipe_ctrl: directed vector bench for pipe_ctrl (4-bit stall counter).   |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stallreq_id_i = 1'b0;
  logic       stallreq_ex_i = 1'b0;
  logic       mc_start_i = 1'b0;
  logic [5:0] mc_len_i = '0;
  logic       flush_i = 1'b0;
  logic [5:0] stall_o;
  logic       flush_o;
  logic [5:0] mc_cnt_o;
  logic       mc_done_o;
  logic       mc_abort_o;
  logic       busy_o;
  logic [3:0] stall_cycles_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(6), .STALL_W(6), .PERF_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id_i  (stallreq_id_i),
    .stallreq_ex_i  (stallreq_ex_i),
    .mc_start_i     (mc_start_i),
    .mc_len_i       (mc_len_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .mc_cnt_o       (mc_cnt_o),
    .mc_done_o      (mc_done_o),
    .mc_abort_o     (mc_abort_o),
    .busy_o         (busy_o),
    .stall_cycles_o (stall_cycles_o)
  );

  typedef struct {
    logic       rst, id, ex, st;
    logic [5:0] len;
    logic       fl;
    logic [5:0] stall;
    logic       fo;
    logic [5:0] cnt;
    logic       done, abt, busy;
    logic [3:0] sc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic id, input logic ex, input logic st,
                              input logic [5:0] len, input logic fl, input logic [5:0] stall,
                              input logic fo, input logic [5:0] cnt, input logic done,
                              input logic abt, input logic busy, input logic [3:0] sc);
    vec_t v;
    v.rst = r; v.id = id; v.ex = ex; v.st = st; v.len = len; v.fl = fl;
    v.stall = stall; v.fo = fo; v.cnt = cnt; v.done = done; v.abt = abt;
    v.busy = busy; v.sc = sc;
    return v;
  endfunction

  // Drive one cycle's inputs after the falling edge, then compare the outputs
  // that correspond to the state left by the previous rising edge.
  task automatic apply(input vec_t v, input string name);
    logic [20:0] act;
    logic [20:0] exp;
    @(negedge clk);
    rst = v.rst; stallreq_id_i = v.id; stallreq_ex_i = v.ex;
    mc_start_i = v.st; mc_len_i = v.len; flush_i = v.fl;
    #2;
    act = {stall_o, flush_o, mc_cnt_o, mc_done_o, mc_abort_o, busy_o, stall_cycles_o};
    exp = {v.stall, v.fo, v.cnt, v.done, v.abt, v.busy, v.sc};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got stall=%b flush=%b cnt=%0d done=%b abort=%b busy=%b sc=%0d, want stall=%b flush=%b cnt=%0d done=%b abort=%b busy=%b sc=%0d",
               name, stall_o, flush_o, mc_cnt_o, mc_done_o, mc_abort_o, busy_o, stall_cycles_o,
               v.stall, v.fo, v.cnt, v.done, v.abt, v.busy, v.sc);
    end
  endtask

  vec_t vecs[$];

  initial begin
    //            rst id ex st len fl | stall fo cnt dn ab by sc
    vecs.push_back(mk(1, 1, 1, 1, 63, 1,  0, 0, 0, 0, 0, 0, 0));  // reset, inputs high
    vecs.push_back(mk(1, 1, 1, 1, 63, 1,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0));  // released
    vecs.push_back(mk(0, 0, 0, 1,  4, 0, 15, 0, 0, 0, 0, 0, 0));  // div N=4, T
    vecs.push_back(mk(0, 0, 0, 1,  4, 0, 15, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1,  4, 0, 15, 0, 2, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 1,  4, 0,  0, 0, 3, 1, 0, 1, 3));  // T+3 done
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 3));  // T+4 idle
    vecs.push_back(mk(0, 0, 0, 1,  1, 0,  0, 0, 0, 1, 0, 0, 3));  // N=1
    vecs.push_back(mk(0, 0, 0, 1,  0, 0,  0, 0, 0, 1, 0, 0, 3));  // len 0 as 1
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0,  7, 0, 0, 0, 0, 0, 3));  // ID only
    vecs.push_back(mk(0, 1, 1, 0,  0, 0, 15, 0, 0, 0, 0, 0, 4));  // ID+EX
    vecs.push_back(mk(0, 0, 0, 1,  3, 0, 15, 0, 0, 0, 0, 0, 5));  // N=3 start
    vecs.push_back(mk(0, 1, 0, 1,  3, 0, 15, 0, 1, 0, 0, 1, 6));  // BUSY + ID
    vecs.push_back(mk(0, 1, 0, 1,  3, 0,  7, 0, 2, 1, 0, 1, 7));  // done + ID
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 8));
    vecs.push_back(mk(0, 1, 1, 1,  5, 1,  0, 1, 0, 0, 0, 0, 8));  // flush beats start
    vecs.push_back(mk(0, 0, 0, 1,  1, 1,  0, 1, 0, 0, 0, 0, 8));  // no done on flush
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 8));
    vecs.push_back(mk(0, 0, 0, 1,  8, 0, 15, 0, 0, 0, 0, 0, 8));  // N=8 start
    vecs.push_back(mk(0, 0, 0, 1,  8, 0, 15, 0, 1, 0, 0, 1, 9));
    vecs.push_back(mk(0, 0, 0, 1,  8, 0, 15, 0, 2, 0, 0, 1, 10));
    vecs.push_back(mk(0, 0, 0, 1,  8, 1,  0, 1, 3, 0, 1, 1, 11)); // flush at cnt 3
    vecs.push_back(mk(0, 0, 0, 0,  8, 0,  0, 0, 0, 0, 0, 0, 11)); // back to IDLE

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Saturation: counter climbs from 11 to 15 and holds there.
    for (int i = 0; i < 20; i++) begin
      apply(mk(0, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, (11 + i > 15) ? 4'd15 : 4'(11 + i)),
            $sformatf("sat%0d", i));
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15), "sat_hold");

    // Reset mid-BUSY abandons the op without an abort pulse.
    apply(mk(0, 0, 0, 1, 10, 0, 15, 0, 0, 0, 0, 0, 15), "rstbusy_start");
    apply(mk(0, 0, 0, 1, 10, 0, 15, 0, 1, 0, 0, 1, 15), "rstbusy_cnt1");
    apply(mk(1, 0, 0, 1, 10, 0,  0, 0, 0, 0, 0, 0, 0),  "rstbusy_rst");
    apply(mk(0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0),  "rstbusy_after");
    apply(mk(0, 1, 0, 0,  0, 0,  7, 0, 0, 0, 0, 0, 0),  "post_rst_id");
    apply(mk(0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 1),  "post_rst_count");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
